// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed display scanner with double-buffered digit data.
// Optional blink feature is compiled in with the macro DISP_BLINK_EN.
module disp_scan_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        wr_en,
    input  logic [15:0] hexs_in,
    input  logic [3:0]  point_in,
    input  logic [3:0]  les_in,
    output logic [1:0]  scan,
    output logic [3:0]  hex,
    output logic        p,
    output logic [3:0]  an,
    output logic        frame_done,
    output logic        pending
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    scan_q, scan_d;
    logic [3:0]    an_q, an_d;
    logic [3:0]    hex_q, hex_d;
    logic          p_q, p_d;
    logic          frame_done_q, frame_done_d;
    logic          pending_q, pending_d;
    logic [15:0]   stg_hex_q, stg_hex_d;
    logic [3:0]    stg_pt_q, stg_pt_d;
    logic [15:0]   shd_hex_q, shd_hex_d;
    logic [3:0]    shd_pt_q, shd_pt_d;
    logic          slot_end_s;
    logic          boundary_s;

`ifdef DISP_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FR_MAX = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          hidden_q, hidden_d;
    logic [3:0]    stg_les_q, stg_les_d;
    logic [3:0]    shd_les_q, shd_les_d;
`else
    logic          les_unused_s;
    assign les_unused_s = ^les_in;
`endif

    // Next-state logic for the slot counter, buffers and registered outputs.
    always_comb begin
        cnt_d        = cnt_q;
        scan_d       = scan_q;
        stg_hex_d    = stg_hex_q;
        stg_pt_d     = stg_pt_q;
        shd_hex_d    = shd_hex_q;
        shd_pt_d     = shd_pt_q;
        pending_d    = pending_q;
        slot_end_s   = en && (cnt_q == CNT_MAX);
        boundary_s   = slot_end_s && (scan_q == 2'd3);
        frame_done_d = boundary_s;
`ifdef DISP_BLINK_EN
        frame_cnt_d  = frame_cnt_q;
        hidden_d     = hidden_q;
        stg_les_d    = stg_les_q;
        shd_les_d    = shd_les_q;
`endif

        if (slot_end_s) begin
            cnt_d  = '0;
            scan_d = scan_q + 2'd1;
        end else if (en) begin
            cnt_d  = cnt_q + CW'(1);
        end else begin
            cnt_d  = cnt_q;
        end

        // Shadow only moves at a frame boundary, so a frame never mixes old and new data.
        if (boundary_s && pending_q) begin
            shd_hex_d = stg_hex_q;
            shd_pt_d  = stg_pt_q;
`ifdef DISP_BLINK_EN
            shd_les_d = stg_les_q;
`endif
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end

        if (wr_en) begin
            stg_hex_d = hexs_in;
            stg_pt_d  = point_in;
`ifdef DISP_BLINK_EN
            stg_les_d = les_in;
`endif
            pending_d = 1'b1;
        end else begin
            stg_hex_d = stg_hex_d;
        end

`ifdef DISP_BLINK_EN
        if (boundary_s && (frame_cnt_q == FR_MAX)) begin
            frame_cnt_d = '0;
            hidden_d    = ~hidden_q;
        end else if (boundary_s) begin
            frame_cnt_d = frame_cnt_q + FW'(1);
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
`endif

        state_d = (cnt_d < BLANK_END) ? ST_BLANK : ST_SHOW;

        case (state_d)
            ST_SHOW:  an_d = ~(4'b0001 << scan_d);
            ST_BLANK: an_d = 4'b1111;
            default:  an_d = 4'b1111;
        endcase
`ifdef DISP_BLINK_EN
        if (hidden_d && shd_les_d[scan_d]) begin
            an_d = 4'b1111;
        end else begin
            an_d = an_d;
        end
`endif

        hex_d = shd_hex_d[{scan_d, 2'b00} +: 4];
        p_d   = shd_pt_d[scan_d];
    end

    // State register with synchronous reset taking priority over wr_en and en.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            scan_q       <= 2'd0;
            an_q         <= 4'b1111;
            hex_q        <= 4'd0;
            p_q          <= 1'b0;
            frame_done_q <= 1'b0;
            pending_q    <= 1'b0;
            stg_hex_q    <= 16'd0;
            stg_pt_q     <= 4'd0;
            shd_hex_q    <= 16'd0;
            shd_pt_q     <= 4'd0;
`ifdef DISP_BLINK_EN
            frame_cnt_q  <= '0;
            hidden_q     <= 1'b0;
            stg_les_q    <= 4'd0;
            shd_les_q    <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            scan_q       <= scan_d;
            an_q         <= an_d;
            hex_q        <= hex_d;
            p_q          <= p_d;
            frame_done_q <= frame_done_d;
            pending_q    <= pending_d;
            stg_hex_q    <= stg_hex_d;
            stg_pt_q     <= stg_pt_d;
            shd_hex_q    <= shd_hex_d;
            shd_pt_q     <= shd_pt_d;
`ifdef DISP_BLINK_EN
            frame_cnt_q  <= frame_cnt_d;
            hidden_q     <= hidden_d;
            stg_les_q    <= stg_les_d;
            shd_les_q    <= shd_les_d;
`endif
        end
    end

    // Dropping en blanks the anodes immediately rather than one cycle late.
    assign an         = an_q | {4{~en}};
    assign scan       = scan_q;
    assign hex        = hex_q;
    assign p          = p_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed self-checking bench for disp_scan_ctrl (SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2).
module tb_disp_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic        wr_en;
    logic [15:0] hexs_in;
    logic [3:0]  point_in;
    logic [3:0]  les_in;
    logic [1:0]  scan;
    logic [3:0]  hex;
    logic        p;
    logic [3:0]  an;
    logic        frame_done;
    logic        pending;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    disp_scan_ctrl #(
        .SCAN_DIV    (8),
        .BLANK_CYC   (2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .wr_en     (wr_en),
        .hexs_in   (hexs_in),
        .point_in  (point_in),
        .les_in    (les_in),
        .scan      (scan),
        .hex       (hex),
        .p         (p),
        .an        (an),
        .frame_done(frame_done),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic advance_to(input int target);
        while (cyc < target) tick();
    endtask

    // Expected anode pattern for a running scan with no blinking.
    function automatic logic [3:0] exp_an(input int c);
        int cnt;
        int sc;
        cnt = c % 8;
        sc  = (c / 8) % 4;
        if (cnt < 2) return 4'b1111;
        return ~(4'b0001 << sc);
    endfunction

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; wr_en = 1'b0;
        hexs_in = 16'h0; point_in = 4'h0; les_in = 4'h0;
        tick();
        rst = 1'b0; en = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; wr_en = 1'b1; hexs_in = 16'hFFFF; point_in = 4'hF;
        tick();
        checks++;
        if (an !== 4'b1111 || scan !== 2'd0 || hex !== 4'd0 || p !== 1'b0 ||
            frame_done !== 1'b0 || pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: an=%b scan=%0d hex=%h p=%b fd=%b pend=%b, want 1111 0 0 0 0 0",
                     an, scan, hex, p, frame_done, pending);
        end
        do_reset();
        checks++;
        if (pending !== 1'b0 || hex !== 4'd0) begin
            errors++;
            $display("FAIL reset_priority: pending=%b hex=%h, want 0 0", pending, hex);
        end
    endtask

    task automatic test_scan();
        do_reset();
        for (int c = 0; c < 80; c++) begin
            checks++;
            if (an !== exp_an(c) || scan !== 2'((c / 8) % 4) ||
                frame_done !== ((c > 0) && (c % 32 == 0))) begin
                errors++;
                $display("FAIL scan_c%0d: an=%b scan=%0d fd=%b, want an=%b scan=%0d fd=%b",
                         c, an, scan, frame_done, exp_an(c), (c / 8) % 4,
                         ((c > 0) && (c % 32 == 0)));
            end
            tick();
        end
    endtask

    task automatic test_update();
        logic [15:0] v;
        logic [3:0]  pt;
        v  = 16'h1234;
        pt = 4'b0101;
        do_reset();
        advance_to(8);
        wr_en = 1'b1; hexs_in = v; point_in = pt;
        tick();
        wr_en = 1'b0;
        for (int c = 9; c < 64; c++) begin
            int sc;
            logic [3:0] eh;
            logic       ep;
            logic       epend;
            sc    = (c / 8) % 4;
            eh    = (c < 32) ? 4'd0 : v[sc*4 +: 4];
            ep    = (c < 32) ? 1'b0 : pt[sc];
            epend = (c < 32);
            checks++;
            if (hex !== eh || p !== ep || pending !== epend) begin
                errors++;
                $display("FAIL update_c%0d: hex=%h p=%b pend=%b, want %h %b %b",
                         c, hex, p, pending, eh, ep, epend);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        advance_to(8);
        wr_en = 1'b1; hexs_in = 16'hAAAA; point_in = 4'h0;
        tick();
        wr_en = 1'b0;
        advance_to(31);
        wr_en = 1'b1; hexs_in = 16'h5555;
        tick();
        wr_en = 1'b0;
        for (int c = 32; c < 96; c++) begin
            logic [3:0] eh;
            logic       epend;
            eh    = (c < 64) ? 4'hA : 4'h5;
            epend = (c < 64);
            checks++;
            if (hex !== eh || pending !== epend) begin
                errors++;
                $display("FAIL b2b_c%0d: hex=%h pend=%b, want %h %b", c, hex, pending, eh, epend);
            end
            tick();
        end
    endtask

    task automatic test_blink();
        do_reset();
        wr_en = 1'b1; hexs_in = 16'h0; point_in = 4'h0; les_in = 4'b0010;
        tick();
        wr_en = 1'b0;
        for (int c = 1; c < 160; c++) begin
            logic [3:0] ea;
            ea = exp_an(c);
`ifdef DISP_BLINK_EN
            if (((c / 32) % 4) >= 2 && ((c / 8) % 4) == 1) ea = 4'b1111;
`endif
            checks++;
            if (an !== ea) begin
                errors++;
                $display("FAIL blink_c%0d: an=%b, want %b", c, an, ea);
            end
            tick();
        end
    endtask

    task automatic test_enable();
        do_reset();
        advance_to(12);
        en = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (an !== 4'b1111 || scan !== 2'd1) begin
                errors++;
                $display("FAIL en_low_%0d: an=%b scan=%0d, want 1111 1", k, an, scan);
            end
            tick();
        end
        en = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (an !== 4'b1101 || scan !== 2'd1) begin
                errors++;
                $display("FAIL en_resume_%0d: an=%b scan=%0d, want 1101 1", k, an, scan);
            end
            tick();
        end
        checks++;
        if (an !== 4'b1111 || scan !== 2'd2) begin
            errors++;
            $display("FAIL en_slot_end: an=%b scan=%0d, want 1111 2", an, scan);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        advance_to(16);
        wr_en = 1'b1; hexs_in = 16'hBEEF; point_in = 4'hF;
        tick();
        wr_en = 1'b0;
        advance_to(20);
        checks++;
        if (pending !== 1'b1 || scan !== 2'd2 || an !== 4'b1011) begin
            errors++;
            $display("FAIL rstmid_pre: pend=%b scan=%0d an=%b, want 1 2 1011", pending, scan, an);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (scan !== 2'd0 || an !== 4'b1111 || hex !== 4'd0 || pending !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_post: scan=%0d an=%b hex=%h pend=%b, want 0 1111 0 0",
                     scan, an, hex, pending);
        end
        cyc = 0;
        advance_to(33);
        checks++;
        if (hex !== 4'd0 || p !== 1'b0 || pending !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_frame: hex=%h p=%b pend=%b, want 0 0 0", hex, p, pending);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; wr_en = 1'b0;
        hexs_in = 16'h0; point_in = 4'h0; les_in = 4'h0;
        test_reset();
        test_scan();
        test_update();
        test_back_to_back();
        test_blink();
        test_enable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
